// File: rtl/sd_read.sv
// sd_read: SD card single-block read engine (CMD17, 512-byte block).
// Sends CMD17, waits for R1 and the 0xFE token, streams 256 16-bit words.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   miso_data[15:0]  MISO history shift register, bit 0 newest
//   sd_init_done     card initialised; gates request acceptance
//   sd_cs            card chip select, active low
//   sd_mosi          command line to the card
//   read_ready       read request, sampled in IDLE only
//   read_address     CMD17 block address
//   read_data        received word, first bit in the MSB
//   read_valid       one-cycle strobe, read_data holds a new word
//   read_busy        high from acceptance until the return to IDLE
//   read_crc_error   block CRC16 mismatch (SD_READ_CRC_EN builds only)
// Build option: define SD_READ_CRC_EN to check the block CRC16.
module sd_read (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] miso_data,
  input  logic        sd_init_done,
  output logic        sd_cs,
  output logic        sd_mosi,
  input  logic        read_ready,
  input  logic [31:0] read_address,
  output logic [15:0] read_data,
  output logic        read_valid,
  output logic        read_busy
`ifdef SD_READ_CRC_EN
  ,
  output logic        read_crc_error
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_CMD17 = 3'd1,
    WAIT_TOKEN = 3'd2,
    READ_DATA  = 3'd3,
    READ_CRC   = 3'd4,
    FINISH     = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [40:0] cmd_new;
  logic [39:0] cmd_q;
  logic [5:0]  cmd_cnt;
  logic        cmd_done;
  logic [3:0]  bit_cnt;
  logic [7:0]  word_cnt;
  logic [15:0] shift_q;
  logic [2:0]  fin_cnt;
  logic        accept;
  logic        r1_seen;
  logic        r1_ok;
  logic        r1_bad;
  logic        token;
  logic        bit_end;
  logic        last_word;
  logic        fin_end;

  assign cmd_new   = {8'h51, read_address, 1'b1};
  assign accept    = read_ready & sd_init_done;
  // A real R1 byte has a clear MSB; a set MSB is still idle bus.
  assign r1_seen   = cmd_done
                   && (miso_data[15:8] == 8'hFF)
                   && !miso_data[7];
  assign r1_ok     = r1_seen && (miso_data[7:0] == 8'h00);
  assign r1_bad    = r1_seen && (miso_data[7:0] != 8'h00);
  assign token     = miso_data[7:0] == 8'hFE;
  assign bit_end   = bit_cnt == 4'hF;
  assign last_word = word_cnt == 8'hFF;
  assign fin_end   = fin_cnt == 3'd7;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (accept) state_n = SEND_CMD17;
      SEND_CMD17: begin
        if (r1_ok)       state_n = WAIT_TOKEN;
        else if (r1_bad) state_n = FINISH;
      end
      WAIT_TOKEN: if (token) state_n = READ_DATA;
      READ_DATA:  if (bit_end && last_word) state_n = READ_CRC;
      READ_CRC:   if (bit_end) state_n = FINISH;
      FINISH:     if (fin_end) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sd_cs      <= 1'b1;
      sd_mosi    <= 1'b1;
      read_busy  <= 1'b0;
      read_valid <= 1'b0;
      read_data  <= '0;
      cmd_q      <= '0;
      cmd_cnt    <= '0;
      cmd_done   <= 1'b0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shift_q    <= '0;
      fin_cnt    <= '0;
    end else begin
      read_valid <= 1'b0;
      fin_cnt    <= '0;
      unique case (state)
        IDLE: begin
          sd_cs     <= 1'b1;
          sd_mosi   <= 1'b1;
          read_busy <= 1'b0;
          if (accept) begin
            cmd_q     <= cmd_new[39:0];
            cmd_cnt   <= 6'd39;
            cmd_done  <= 1'b0;
            sd_cs     <= 1'b0;
            read_busy <= 1'b1;
            sd_mosi   <= cmd_new[40];
          end
        end
        SEND_CMD17: begin
          if (!cmd_done) begin
            sd_mosi <= cmd_q[39];
            cmd_q   <= {cmd_q[38:0], 1'b0};
            if (cmd_cnt == 6'd0) cmd_done <= 1'b1;
            else                 cmd_cnt  <= cmd_cnt - 6'd1;
          end else begin
            sd_mosi <= 1'b1;
          end
        end
        WAIT_TOKEN: begin
          if (token) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end
        READ_DATA: begin
          shift_q <= {shift_q[14:0], miso_data[0]};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_end) begin
            read_data  <= {shift_q[14:0], miso_data[0]};
            read_valid <= 1'b1;
            word_cnt   <= word_cnt + 8'd1;
          end
        end
        READ_CRC: begin
          bit_cnt <= bit_cnt + 4'd1;
        end
        FINISH: begin
          fin_cnt <= fin_cnt + 3'd1;
          sd_mosi <= 1'b1;
          if (fin_end) begin
            sd_cs     <= 1'b1;
            read_busy <= 1'b0;
          end
        end
        default: begin
          sd_cs     <= 1'b1;
          sd_mosi   <= 1'b1;
          read_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef SD_READ_CRC_EN
  logic [15:0] crc_calc;
  logic [15:0] crc_rx;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    crc_step = {c[14:0], 1'b0}
             ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_calc       <= '0;
      crc_rx         <= '0;
      read_crc_error <= 1'b0;
    end else begin
      if (state == IDLE && accept)
        read_crc_error <= 1'b0;
      if (state == WAIT_TOKEN && token)
        crc_calc <= '0;
      if (state == READ_DATA)
        crc_calc <= crc_step(crc_calc, miso_data[0]);
      if (state == READ_CRC) begin
        crc_rx <= {crc_rx[14:0], miso_data[0]};
        if (bit_end)
          read_crc_error <=
            ({crc_rx[14:0], miso_data[0]} != crc_calc);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sd_read.sv
// tb_sd_read: directed bench for sd_read with a bit-level card model.
// Card replies are queued bits; words are checked against a queue.
module tb_sd_read;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic [15:0] miso_data    = 16'hFFFF;
  logic        sd_init_done = 1'b0;
  logic        sd_cs;
  logic        sd_mosi;
  logic        read_ready   = 1'b0;
  logic [31:0] read_address = '0;
  logic [15:0] read_data;
  logic        read_valid;
  logic        read_busy;
`ifdef SD_READ_CRC_EN
  logic        read_crc_error;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_valid = 0;
  bit          bitq[$];
  logic [15:0] exp_words[$];
  logic [15:0] last_data = '0;

  sd_read dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .miso_data    (miso_data),
    .sd_init_done (sd_init_done),
    .sd_cs        (sd_cs),
    .sd_mosi      (sd_mosi),
    .read_ready   (read_ready),
    .read_address (read_address),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .read_busy    (read_busy)
`ifdef SD_READ_CRC_EN
    ,
    .read_crc_error (read_crc_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- model ----
  function automatic logic [40:0] cmd_of(input logic [31:0] a);
    cmd_of = {8'h51, a[31:24], a[23:16], a[15:8], a[7:0], 1'b1};
  endfunction

  function automatic logic [15:0] word_of(input int pat, input int i);
    logic [15:0] ii;
    ii = 16'(i);
    case (pat)
      0:       word_of = ii;
      1:       word_of = 16'(ii * 16'h9E37) ^ 16'h5A5A;
      default: word_of = {ii[7:0], ~ii[7:0]};
    endcase
  endfunction

  function automatic logic [15:0] crc_bit(input logic [15:0] c,
                                          input logic b);
    logic [15:0] r;
    r = c << 1;
    if (c[15] != b) r = r ^ 16'h1021;
    crc_bit = r;
  endfunction

  function automatic logic [15:0] crc_word(input logic [15:0] c,
                                           input logic [15:0] w);
    logic [15:0] r;
    r = c;
    for (int b = 15; b >= 0; b--) r = crc_bit(r, w[b]);
    crc_word = r;
  endfunction

  task automatic push_byte(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) bitq.push_back(v[b]);
  endtask

  task automatic push_word(input logic [15:0] v);
    for (int b = 15; b >= 0; b--) bitq.push_back(v[b]);
  endtask

  // Card: one MISO bit per clock, idle high.
  always @(negedge clk) begin
    logic b;
    b = 1'b1;
    if (bitq.size() > 0) b = bitq.pop_front();
    miso_data = {miso_data[14:0], b};
  end

  // Word scoreboard and hold check.
  always @(negedge clk) begin
    logic [15:0] w;
    if (!rst_n) begin
      last_data = '0;
    end else if (read_valid) begin
      n_valid++;
      if (exp_words.size() == 0) begin
        chk("unexpected_valid", 1'b1, 1'b0);
      end else begin
        w = exp_words.pop_front();
        chk("read_data", read_data, w);
        last_data = w;
      end
    end else begin
      chk("read_data_hold", read_data, last_data);
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] addr,
                         input logic [7:0]  r1,
                         input int          pat,
                         input bit          corrupt,
                         input bit          hold_rdy,
                         input bit          drop_init,
                         input int          rst_word);
    logic [40:0] cmd;
    logic [15:0] w;
    logic [15:0] crc;
    int          base;
    int          k;
    cmd  = cmd_of(addr);
    base = n_valid;
    tick();
    read_address = addr;
    read_ready   = 1'b1;
    tick();
    chk("cs_fall", sd_cs, 1'b0);
    chk("busy_rise", read_busy, 1'b1);
    if (hold_rdy) read_address = ~addr;
    else          read_ready   = 1'b0;
    if (drop_init) sd_init_done = 1'b0;
    for (int i = 40; i >= 0; i--) begin
      if (i != 40) tick();
      chk("mosi_cmd", sd_mosi, cmd[i]);
    end
    tick();
    chk("mosi_after_cmd", sd_mosi, 1'b1);
    read_ready = 1'b0;
    repeat (8) bitq.push_back(1'b1);
    push_byte(r1);
    if (r1 != 8'h00) begin
      k = 0;
      while (bitq.size() > 0 && k < 200) begin tick(); k++; end
      chk("r1_drained", k < 200, 1'b1);
      k = 0;
      while (sd_cs !== 1'b1 && k < 20) begin tick(); k++; end
      chk("abort_cs_within_9", k <= 9, 1'b1);
      chk("abort_busy", read_busy, 1'b0);
      chk("abort_no_words", n_valid, base);
`ifdef SD_READ_CRC_EN
      chk("abort_crc_err", read_crc_error, 1'b0);
`endif
    end else begin
      repeat (8) bitq.push_back(1'b1);
      push_byte(8'hFE);
      crc = '0;
      for (int i = 0; i < 256; i++) begin
        w = word_of(pat, i);
        exp_words.push_back(w);
        push_word(w);
        crc = crc_word(crc, w);
      end
      if (corrupt) crc = crc ^ 16'h0100;
      push_word(crc);
      if (rst_word >= 0) begin
        k = 0;
        while (n_valid < base + rst_word && k < 6000) begin
          tick(); k++;
        end
        chk("reached_rst_word", k < 6000, 1'b1);
        repeat (5) tick();
        rst_n = 1'b0;
        exp_words.delete();
        bitq.delete();
        #1;
        chk("rst_mid_cs", sd_cs, 1'b1);
        chk("rst_mid_busy", read_busy, 1'b0);
        chk("rst_mid_valid", read_valid, 1'b0);
        chk("rst_mid_data", read_data, 16'h0000);
        repeat (3) tick();
        rst_n = 1'b1;
        base  = n_valid;
        repeat (300) tick();
        chk("no_valid_after_rst", n_valid, base);
        chk("cs_after_rst", sd_cs, 1'b1);
      end else begin
        k = 0;
        while (n_valid < base + 256 && k < 6000) begin
          tick(); k++;
        end
        chk("words_in_time", k < 6000, 1'b1);
        chk("word_count", n_valid - base, 256);
        k = 0;
        while (sd_cs !== 1'b1 && k < 40) begin tick(); k++; end
        chk("cs_rise_after_crc_finish", k, 24);
        chk("busy_end", read_busy, 1'b0);
        chk("all_words_seen", exp_words.size(), 0);
`ifdef SD_READ_CRC_EN
        chk("crc_error", read_crc_error, corrupt);
`endif
      end
    end
    sd_init_done = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    logic [7:0]  ch;
    repeat (2) tick();
    chk("rst_cs", sd_cs, 1'b1);
    chk("rst_mosi", sd_mosi, 1'b1);
    chk("rst_busy", read_busy, 1'b0);
    chk("rst_valid", read_valid, 1'b0);
    chk("rst_data", read_data, 16'h0000);
`ifdef SD_READ_CRC_EN
    chk("rst_crc_err", read_crc_error, 1'b0);
`endif
    rst_n        = 1'b1;
    sd_init_done = 1'b1;
    tick();

    // Pin the model with hand-computed values.
    chk("model_cmd", cmd_of(32'h0000_0010), 41'h0A2_0000_0021);
    c = '0;
    for (int i = 0; i < 9; i++) begin
      ch = 8'(8'h31 + i);
      for (int b = 7; b >= 0; b--) c = crc_bit(c, ch[b]);
    end
    chk("model_crc_123456789", c, 16'h31C3);
    chk("model_word1_0", word_of(1, 0), 16'h5A5A);
    chk("model_word1_1", word_of(1, 1), 16'hC46D);

    // Request while the card is not initialised.
    sd_init_done = 1'b0;
    read_ready   = 1'b1;
    read_address = 32'h0000_0010;
    repeat (5) begin
      tick();
      chk("noinit_cs", sd_cs, 1'b1);
      chk("noinit_busy", read_busy, 1'b0);
    end
    read_ready   = 1'b0;
    sd_init_done = 1'b1;
    tick();

    do_read(32'h0000_0010, 8'h00, 0, 1'b0, 1'b0, 1'b0, -1);
    do_read(32'hDEAD_BEEF, 8'h00, 1, 1'b0, 1'b1, 1'b1, -1);
    do_read(32'h0000_0200, 8'h04, 0, 1'b0, 1'b0, 1'b0, -1);
    do_read(32'h0000_0100, 8'h00, 2, 1'b0, 1'b0, 1'b0, 100);
    do_read(32'h0000_0020, 8'h00, 1, 1'b1, 1'b0, 1'b0, -1);
    do_read(32'h0000_0040, 8'h00, 2, 1'b0, 1'b0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
